wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/cpu_pkg.sv | 16 +
 rtl/wb_fifo.sv | 69 ++++++
 rtl/wb_arbiter.sv | 101 ++++++++++
 tb/tb_wb_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the writeback path.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned REG_DATA_W    = 32;
    localparam int unsigned WB_FIFO_DEPTH = 4;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One register-file write: destination and data.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage : cpu_pkg

// File: rtl/wb_fifo.sv
// Small circular buffer holding LSU results that lost arbitration.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = WB_FIFO_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  wb_entry_t                push_entry_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output wb_entry_t                head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q,  count_d;
    logic                 push_ok;
    logic                 pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Ignore illegal push-when-full / pop-when-empty so state can never corrupt.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i  && !empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_entry_i;
    end

endmodule : wb_fifo

// File: rtl/wb_arbiter.sv
// Merges ALU and LSU results onto the single register-file write port.
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        alu_valid_i,
    input  logic [4:0]                  alu_rd_addr_i,
    input  logic [31:0]                 alu_rd_data_i,
    input  logic                        lsu_valid_i,
    input  logic [4:0]                  lsu_rd_addr_i,
    input  logic [31:0]                 lsu_rd_data_i,
    output logic                        lsu_ready_o,
    output logic                        rd_wren_o,
    output logic [4:0]                  rd_addr_o,
    output logic [31:0]                 rd_data_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t          alu_entry;
    wb_entry_t          lsu_entry;
    wb_entry_t          head_entry;
    wb_entry_t          rd_q, rd_d;
    logic               rd_wren_q, rd_wren_d;
    logic               rst_done_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_push;
    logic               fifo_pop;
    logic               alu_live;
    logic               lsu_live;

    assign alu_entry = '{addr: alu_rd_addr_i, data: alu_rd_data_i};
    assign lsu_entry = '{addr: lsu_rd_addr_i, data: lsu_rd_data_i};

    // Ready comes only from registers; held low until the first edge after reset.
    assign lsu_ready_o = rst_done_q && !fifo_full;

    // x0 results are accepted but treated as if they never arrived.
    assign alu_live = alu_valid_i && (alu_rd_addr_i != REG_ZERO);
    assign lsu_live = lsu_valid_i && lsu_ready_o && (lsu_rd_addr_i != REG_ZERO);

    // Fixed priority: live ALU, then buffered load, then bypassed load.
    always_comb begin
        rd_wren_d = 1'b0;
        rd_d      = rd_q;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (alu_live) begin
            rd_wren_d = 1'b1;
            rd_d      = alu_entry;
            fifo_push = lsu_live;
        end else if (!fifo_empty) begin
            rd_wren_d = 1'b1;
            rd_d      = head_entry;
            fifo_pop  = 1'b1;
            fifo_push = lsu_live;
        end else if (lsu_live) begin
            rd_wren_d = 1'b1;
            rd_d      = lsu_entry;
        end
    end

    // Write-port output register; address/data hold when nothing is selected.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_wren_q  <= 1'b0;
            rd_q       <= '0;
            rst_done_q <= 1'b0;
        end else begin
            rd_wren_q  <= rd_wren_d;
            rd_q       <= rd_d;
            rst_done_q <= 1'b1;
        end
    end

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (fifo_push),
        .push_entry_i (lsu_entry),
        .pop_i        (fifo_pop),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count),
        .head_o       (head_entry)
    );

    assign rd_wren_o    = rd_wren_q;
    assign rd_addr_o    = rd_q.addr;
    assign rd_data_o    = rd_q.data;
    assign fifo_count_o = fifo_count;

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed vectors, monitor checks every write.
module tb_wb_arbiter;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_addr  = '0;
    logic [31:0] alu_data  = '0;
    logic        lsu_valid = 1'b0;
    logic [4:0]  lsu_addr  = '0;
    logic [31:0] lsu_data  = '0;
    logic        lsu_ready;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [2:0]  fifo_count;

    int n_vec = 0;
    int n_err = 0;
    wb_entry_t exp_q[$];

    wb_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .alu_valid_i   (alu_valid),
        .alu_rd_addr_i (alu_addr),
        .alu_rd_data_i (alu_data),
        .lsu_valid_i   (lsu_valid),
        .lsu_rd_addr_i (lsu_addr),
        .lsu_rd_data_i (lsu_data),
        .lsu_ready_o   (lsu_ready),
        .rd_wren_o     (rd_wren),
        .rd_addr_o     (rd_addr),
        .rd_data_o     (rd_data),
        .fifo_count_o  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    // Monitor: every write the DUT presents must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && rd_wren) begin
            wb_entry_t e;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got x%0d=0x%08h expected no write at %0t",
                         rd_addr, rd_data, $time);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(rd_addr), 32'(e.addr));
                chk("wr_data", rd_data, e.data);
            end
        end
    end

    initial begin
        int k;
        int guard;
        logic acc;

        // Reset values while rst is held.
        step();
        step();
        chk("rst_wren",  32'(rd_wren), 32'd0);
        chk("rst_addr",  32'(rd_addr), 32'd0);
        chk("rst_data",  rd_data, 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(lsu_ready), 32'd0);
        rst = 1'b0;
        chk("ready_before_edge", 32'(lsu_ready), 32'd0);
        step();
        chk("ready_after_rel", 32'(lsu_ready), 32'd1);
        chk("count_after_rel", 32'(fifo_count), 32'd0);
        chk("wren_after_rel",  32'(rd_wren), 32'd0);

        // ALU only.
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        expect_wr(5'd5, 32'hDEADBEEF);
        step();
        alu_valid = 1'b0;
        chk("alu_wren", 32'(rd_wren), 32'd1);
        chk("alu_addr", 32'(rd_addr), 32'd5);
        step();
        chk("idle_wren", 32'(rd_wren), 32'd0);
        chk("idle_addr_hold", 32'(rd_addr), 32'd5);
        chk("idle_data_hold", rd_data, 32'hDEADBEEF);

        // Collision: ALU wins, load buffered then retired.
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'h22;
        expect_wr(5'd3, 32'h11);
        expect_wr(5'd7, 32'h22);
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        chk("coll_c1_addr",  32'(rd_addr), 32'd3);
        chk("coll_c1_count", 32'(fifo_count), 32'd1);
        step();
        chk("coll_c2_addr",  32'(rd_addr), 32'd7);
        chk("coll_c2_count", 32'(fifo_count), 32'd0);
        step();

        // x0 filter: ALU to x0 does not block the bypassed load.
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h99;
        lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h33;
        expect_wr(5'd9, 32'h33);
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        chk("x0_wren",  32'(rd_wren), 32'd1);
        chk("x0_addr",  32'(rd_addr), 32'd9);
        chk("x0_count", 32'(fifo_count), 32'd0);
        step();

        // Fill: ALU busy every cycle, six loads offered.
        k = 0;
        for (int c = 0; c < 8; c++) begin
            alu_valid = 1'b1; alu_addr = 5'(10 + c); alu_data = 32'hA000 + 32'(c);
            expect_wr(alu_addr, alu_data);
            lsu_valid = (k < 6);
            lsu_addr  = 5'(20 + k); lsu_data = 32'hC000 + 32'(k);
            acc = lsu_valid && lsu_ready;
            step();
            if (acc) k++;
        end
        alu_valid = 1'b0;
        for (int j = 0; j < 6; j++) expect_wr(5'(20 + j), 32'hC000 + 32'(j));
        chk("fill_count",    32'(fifo_count), 32'd4);
        chk("fill_ready",    32'(lsu_ready), 32'd0);
        chk("fill_accepted", 32'(k), 32'd4);
        // Pop while full must not admit the held load in the same cycle.
        step();
        chk("full_pop_count", 32'(fifo_count), 32'd3);
        guard = 0;
        while (k < 6 && guard < 50) begin
            lsu_addr = 5'(20 + k); lsu_data = 32'hC000 + 32'(k);
            acc = lsu_valid && lsu_ready;
            step();
            if (acc) k++;
            guard++;
        end
        lsu_valid = 1'b0;
        chk("fill_all_accepted", 32'(k), 32'd6);
        guard = 0;
        while (fifo_count != 0 && guard < 20) begin
            step();
            guard++;
        end
        chk("fill_drained", 32'(fifo_count), 32'd0);
        step();
        step();

        // Reset mid-run with three buffered loads and a write in flight.
        for (int c = 0; c < 3; c++) begin
            alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'hB0 + 32'(c);
            if (c < 2) expect_wr(alu_addr, alu_data);
            lsu_valid = 1'b1; lsu_addr = 5'(25 + c); lsu_data = 32'hE000 + 32'(c);
            step();
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        rst = 1'b1;
        #1;
        chk("async_rst_wren",  32'(rd_wren), 32'd0);
        chk("async_rst_addr",  32'(rd_addr), 32'd0);
        chk("async_rst_data",  rd_data, 32'd0);
        chk("async_rst_count", 32'(fifo_count), 32'd0);
        chk("async_rst_ready", 32'(lsu_ready), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(lsu_ready), 32'd1);
        chk("post_rst_wren",  32'(rd_wren), 32'd0);
        for (int c = 0; c < 6; c++) step();
        chk("post_rst_count", 32'(fifo_count), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_wb_arbiter
